// File: rtl/zap_mem_walker_pkg.sv
// Shared encodings and data generator for the ZAP data-RAM march walker.
package zap_mem_walker_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR0  = 3'd1;
  localparam logic [2:0] ST_RD0  = 3'd2;
  localparam logic [2:0] ST_WR1  = 3'd3;
  localparam logic [2:0] ST_RD1  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [3:0] BEN_ALL = 4'hF;

  // Second march pass writes and checks the bitwise complement of the first.
  function automatic logic [31:0] gen_data(input logic [31:0] addr,
                                           input logic [31:0] pattern,
                                           input logic        inv);
    logic [31:0] raw;
    raw = addr ^ pattern;
    gen_data = inv ? ~raw : raw;
  endfunction

endpackage

// File: rtl/zap_mem_walker_agen.sv
// Word address walker with last-word flag and expected-data generation.
module zap_mem_walker_agen
  import zap_mem_walker_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0100,
  parameter int unsigned WORD_COUNT = 16,
  parameter logic [31:0] PATTERN    = 32'hA5C3_0F96
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic        i_inv,
  output logic [31:0] o_addr,
  output logic        o_last,
  output logic [31:0] o_exp_data
);

  localparam logic [20:0] LAST_IDX = 21'(WORD_COUNT - 1);

  logic [31:0] addr;
  logic [20:0] remain;

  // remain is a down-counter of words left after the current one; zero marks the last word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr   <= 32'd0;
      remain <= 21'd0;
    end else if (i_load) begin
      addr   <= START_ADDR;
      remain <= LAST_IDX;
    end else if (i_advance) begin
      if (remain == 21'd0) begin
        addr   <= START_ADDR;
        remain <= LAST_IDX;
      end else begin
        addr   <= addr + 32'd4;
        remain <= remain - 21'd1;
      end
    end
  end

  assign o_addr     = addr;
  assign o_last     = (remain == 21'd0);
  assign o_exp_data = gen_data(addr, PATTERN, i_inv);

endmodule

// File: rtl/zap_mem_walker.sv
// Four-phase march tester driving the ZAP data-RAM request protocol.
//   state   | meaning
//   IDLE    | waiting for i_start after reset
//   WR0     | writing addr ^ PATTERN to every word
//   RD0     | reading back and comparing against addr ^ PATTERN
//   WR1     | writing ~(addr ^ PATTERN) to every word
//   RD1     | reading back and comparing against the complement
//   DONE    | result valid, waiting for the next i_start
module zap_mem_walker
  import zap_mem_walker_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0100,
  parameter int unsigned WORD_COUNT = 16,
  parameter logic [31:0] PATTERN    = 32'hA5C3_0F96,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic             o_dram_wr_en,
  output logic             o_dram_rd_en,
  output logic [31:0]      o_dram_addr,
  output logic [31:0]      o_dram_data,
  output logic [3:0]       o_dram_ben,
  input  logic [31:0]      i_dram_data,
  input  logic             i_dram_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [31:0]      o_first_err_addr
);

  generate
    if (START_ADDR[1:0] != 2'b00) begin : g_bad_align
      $error("zap_mem_walker: START_ADDR must be 4-byte aligned");
    end
    if (WORD_COUNT == 0 || WORD_COUNT > (1 << 20)) begin : g_bad_count
      $error("zap_mem_walker: WORD_COUNT must be in 1..2^20");
    end
  endgenerate

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             req_wr;
  logic             req_rd;
  logic             accept;
  logic             start_ok;
  logic             phase_inv;
  logic             mismatch;
  logic [31:0]      addr;
  logic             last;
  logic [31:0]      exp_data;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      first_err_addr;

  assign req_wr    = (state == ST_WR0) || (state == ST_WR1);
  assign req_rd    = (state == ST_RD0) || (state == ST_RD1);
  assign accept    = (req_wr || req_rd) && !i_dram_stall;
  assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && i_start;
  assign phase_inv = (state == ST_WR1) || (state == ST_RD1);
  assign mismatch  = accept && req_rd && (i_dram_data != exp_data);

  zap_mem_walker_agen #(
    .START_ADDR (START_ADDR),
    .WORD_COUNT (WORD_COUNT),
    .PATTERN    (PATTERN)
  ) u_agen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (start_ok),
    .i_advance  (accept),
    .i_inv      (phase_inv),
    .o_addr     (addr),
    .o_last     (last),
    .o_exp_data (exp_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_WR0;
      ST_WR0:           if (accept && last) state_nxt = ST_RD0;
      ST_RD0:           if (accept && last) state_nxt = ST_WR1;
      ST_WR1:           if (accept && last) state_nxt = ST_RD1;
      ST_RD1:           if (accept && last) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The first-error capture keys off the pre-increment count so only the first mismatch latches.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_count      <= '0;
      first_err_addr <= 32'd0;
    end else if (start_ok) begin
      err_count      <= '0;
      first_err_addr <= 32'd0;
    end else if (mismatch) begin
      if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
      if (err_count == '0) begin
        first_err_addr <= addr;
      end
    end
  end

  // Request fields derive only from registered state, so they hold steady while stalled.
  assign o_dram_wr_en     = req_wr;
  assign o_dram_rd_en     = req_rd;
  assign o_dram_addr      = addr;
  assign o_dram_data      = req_wr ? exp_data : 32'd0;
  assign o_dram_ben       = (req_wr || req_rd) ? BEN_ALL : 4'h0;
  assign o_busy           = req_wr || req_rd;
  assign o_done           = (state == ST_DONE);
  assign o_pass           = (state == ST_DONE) && (err_count == '0);
  assign o_err_count      = err_count;
  assign o_first_err_addr = first_err_addr;

endmodule

// File: tb/tb_zap_mem_walker.sv
// Directed self-checking bench for zap_mem_walker with a small RAM responder model.
module tb_zap_mem_walker;

  localparam logic [31:0] PAT  = 32'hA5C3_0F96;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [31:0] rdata;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  logic        o_dram_wr_en, o_dram_rd_en, o_busy, o_done, o_pass;
  logic [31:0] o_dram_addr, o_dram_data, o_first_err_addr;
  logic [3:0]  o_dram_ben;
  logic [15:0] o_err_count;

  logic        s_wr_en, s_rd_en, s_busy, s_done, s_pass;
  logic [31:0] s_addr, s_data, s_first;
  logic [3:0]  s_ben;
  logic [1:0]  s_err;

  always #5 clk = ~clk;

  zap_mem_walker #(.START_ADDR(BASE), .WORD_COUNT(4), .PATTERN(PAT), .ERR_W(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_dram_wr_en(o_dram_wr_en), .o_dram_rd_en(o_dram_rd_en),
    .o_dram_addr(o_dram_addr), .o_dram_data(o_dram_data), .o_dram_ben(o_dram_ben),
    .i_dram_data(rdata), .i_dram_stall(stall),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr)
  );

  // Second instance: responder always returns zero, narrow error counter to show saturation.
  zap_mem_walker #(.START_ADDR(BASE), .WORD_COUNT(4), .PATTERN(PAT), .ERR_W(2)) dut_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_dram_wr_en(s_wr_en), .o_dram_rd_en(s_rd_en),
    .o_dram_addr(s_addr), .o_dram_data(s_data), .o_dram_ben(s_ben),
    .i_dram_data(zero32), .i_dram_stall(zero1),
    .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
    .o_err_count(s_err), .o_first_err_addr(s_first)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [4];
  logic [31:0] wlog [4];
  logic [31:0] walog [4];
  int mode, stall_pct;
  int edges, stalls, rd_cnt, wr_cnt, done_at;
  int stab_bad, proto_bad;
  logic [70:0] prev_fields;
  bit prev_stalled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, respond, then take the rising edge and update the model.
  task automatic step(input bit st, output bit done_seen);
    logic [1:0] idx;
    bit req, wr;
    logic [31:0] wd;
    @(negedge clk);
    done_seen = o_done;
    start = st;
    wr  = o_dram_wr_en;
    wd  = o_dram_data;
    req = o_dram_wr_en | o_dram_rd_en;
    if (o_dram_wr_en && o_dram_rd_en) proto_bad++;
    if (o_dram_ben !== (req ? 4'hF : 4'h0)) proto_bad++;
    if (prev_stalled && ({o_dram_wr_en, o_dram_rd_en, o_dram_addr, o_dram_data, o_dram_ben} !== prev_fields))
      stab_bad++;
    stall = req && ($urandom_range(0, 99) < stall_pct);
    idx = o_dram_addr[3:2];
    rdata = 32'd0;
    if (o_dram_rd_en) begin
      rdata = (mode == 2) ? 32'd0 : mem[idx];
      if (mode == 1 && rd_cnt < 4 && o_dram_addr == 32'h108) rdata ^= 32'd1;
    end
    prev_fields  = {o_dram_wr_en, o_dram_rd_en, o_dram_addr, o_dram_data, o_dram_ben};
    prev_stalled = req && stall;
    @(posedge clk);
    edges++;
    if (req && !stall) begin
      if (wr) begin
        mem[idx] = wd;
        if (wr_cnt < 4) begin
          wlog[wr_cnt]  = wd;
          walog[wr_cnt] = BASE + 32'(4 * wr_cnt);
          if (o_dram_addr !== walog[wr_cnt]) proto_bad++;
        end
        wr_cnt++;
      end else begin
        rd_cnt++;
      end
    end else if (req) begin
      stalls++;
    end
  endtask

  task automatic run(input bit hold);
    bit d;
    edges = 0; stalls = 0; rd_cnt = 0; wr_cnt = 0; done_at = -1;
    prev_stalled = 1'b0;
    step(1'b1, d);
    for (int k = 0; k < 400; k++) begin
      step(hold, d);
      if (d) begin
        done_at = edges - 1;
        break;
      end
    end
  endtask

  task automatic check_complement_mem(input string tag);
    for (int i = 0; i < 4; i++)
      chk(tag, mem[i], ~((BASE + 32'(4 * i)) ^ PAT));
  endtask

  initial begin
    bit d;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; rdata = 32'd0;
    mode = 0; stall_pct = 0; stab_bad = 0; proto_bad = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    #1;
    chk("reset_req", {30'd0, o_dram_wr_en, o_dram_rd_en}, 32'd0);
    chk("reset_addr", o_dram_addr, 32'd0);
    chk("reset_status", {28'd0, o_dram_ben[0], o_busy, o_done, o_pass}, 32'd0);
    chk("reset_err", {16'd0, o_err_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean, zero-stall run.
    run(1'b0);
    chk("clean_done_cycle", 32'(done_at), 32'd17);
    chk("clean_pass", {31'd0, o_pass}, 32'd1);
    chk("clean_err", {16'd0, o_err_count}, 32'd0);
    chk("clean_first", o_first_err_addr, 32'd0);
    chk("wr0_data0", wlog[0], 32'hA5C3_0E96);
    chk("wr0_data1", wlog[1], 32'hA5C3_0E92);
    chk("wr0_data2", wlog[2], 32'hA5C3_0E9E);
    chk("wr0_data3", wlog[3], 32'hA5C3_0E9A);
    chk("done_req_low", {30'd0, o_dram_wr_en, o_dram_rd_en}, 32'd0);
    chk("done_addr_reload", o_dram_addr, BASE);
    check_complement_mem("clean_mem");

    // Random stall: fields held while stalled, one cycle per stall.
    stall_pct = 50;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1234_0000 + 32'(i);
    run(1'b0);
    chk("stall_done_cycle", 32'(done_at), 32'(17 + stalls));
    chk("stall_pass", {31'd0, o_pass}, 32'd1);
    check_complement_mem("stall_mem");
    stall_pct = 0;

    // Single bit flip at 0x108 during RD0.
    mode = 1;
    run(1'b0);
    chk("flip_err", {16'd0, o_err_count}, 32'd1);
    chk("flip_first", o_first_err_addr, 32'h108);
    chk("flip_pass", {31'd0, o_pass}, 32'd0);

    // All reads return zero.
    mode = 2;
    run(1'b0);
    chk("zero_err", {16'd0, o_err_count}, 32'd8);
    chk("zero_first", o_first_err_addr, BASE);
    chk("zero_pass", {31'd0, o_pass}, 32'd0);
    chk("sat_done", {31'd0, s_done}, 32'd1);
    chk("sat_err", {30'd0, s_err}, 32'd3);
    chk("sat_first", s_first, BASE);
    chk("sat_idle_bus", {s_wr_en, s_rd_en, s_busy, s_pass, s_ben, s_data[27:0]}, 32'd0);
    chk("sat_addr", s_addr, BASE);

    // i_start held high: ignored while busy, restarts right after DONE and clears counters.
    run(1'b1);
    chk("hold_done_cycle", 32'(done_at), 32'd17);
    #1;
    chk("hold_restart_busy", {30'd0, o_busy, o_done}, 32'd2);
    chk("hold_restart_err", {16'd0, o_err_count}, 32'd0);
    chk("hold_restart_first", o_first_err_addr, 32'd0);
    mode = 0;
    done_at = -1;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, d);
      if (d) begin
        done_at = k;
        break;
      end
    end
    chk("hold_rerun_finished", {31'd0, done_at >= 0}, 32'd1);
    chk("hold_rerun_pass", {31'd0, o_pass}, 32'd1);

    // Asynchronous reset mid-RD0 while stalled.
    edges = 0; stalls = 0; rd_cnt = 0; wr_cnt = 0; prev_stalled = 1'b0;
    step(1'b1, d);
    repeat (4) step(1'b0, d);
    @(negedge clk);
    stall = 1'b1;
    #1;
    chk("pre_reset_rd", {31'd0, o_dram_rd_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", {28'd0, o_dram_wr_en, o_dram_rd_en, o_busy, o_done}, 32'd0);
    chk("async_bus", o_dram_addr | o_dram_data | {28'd0, o_dram_ben}, 32'd0);
    chk("async_status", {15'd0, o_pass, o_err_count} | o_first_err_addr, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold_req", {30'd0, o_dram_wr_en, o_dram_rd_en}, 32'd0);
    end
    rst_n = 1'b1;
    stall = 1'b0;
    run(1'b0);
    chk("post_reset_cycle", 32'(done_at), 32'd17);
    chk("post_reset_pass", {31'd0, o_pass}, 32'd1);

    chk("stall_stability", 32'(stab_bad), 32'd0);
    chk("protocol", 32'(proto_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
